pds_target: RTL and testbench

- Generic 68000-bus responder (slave) on the Mac SE PDS bus, clocked by C8M.
- Decodes a 64 KB address window and terminates matching cycles with DTACK after a programmable number of wait states.
- Holds an 8 x 16-bit register file with UDS/LDS byte-lane writes; word 0 is exported as a control register and word 7 is a read-only ID.
- This is the PDS-side target that our 68030-to-68000 bus master drives, used for accelerator-card control and status.

---
 rtl/pds_target.sv | 198 +++++++++++++++++++
 tb/tb_pds_target.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pds_target.sv
`default_nettype none
// ============================================================================
// Module   : pds_target
// Purpose  : 68000-style bus responder on the Mac SE PDS bus. Decodes a
//            64 KB window at pdsAddr[23:16] = BASE_ADDR, holds an 8 x 16-bit
//            register file with UDS/LDS byte-lane writes, and terminates
//            matching cycles with open-drain DTACK after WAIT_STATES extra
//            clocks. Register 0 is exported as ctrlReg; register 7 reads
//            back the constant ID_VALUE and ignores writes.
// Ports    : pdsC8m      - 8 MHz PDS clock (rising edge)
//            npdsReset   - asynchronous active-low reset
//            npdsAs      - address strobe (active low)
//            npdsUds     - upper data strobe, lane [15:8] (active low)
//            npdsLds     - lower data strobe, lane [7:0] (active low)
//            pdsRnW      - 1 = read, 0 = write
//            pdsAddr     - word address [23:1]
//            pdsDataIn   - write data from the bus
//            pdsDataOut  - read data to the bus
//            pdsDataOe   - read-data driver enable
//            npdsDtack   - open-drain DTACK (0 or Z only)
//            ctrlReg     - live contents of register 0
//            regWrStb    - one-cycle pulse after every register write
//            regWrIdx    - index of the write reported by regWrStb
// Revision : 1.0 - initial release
// ============================================================================
module pds_target #(
  parameter logic [7:0]  BASE_ADDR   = 8'hF8,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] ID_VALUE    = 16'h5E30
) (
  input  logic        pdsC8m,
  input  logic        npdsReset,
  input  logic        npdsAs,
  input  logic        npdsUds,
  input  logic        npdsLds,
  input  logic        pdsRnW,
  input  logic [23:1] pdsAddr,
  input  logic [15:0] pdsDataIn,
  output logic [15:0] pdsDataOut,
  output logic        pdsDataOe,
  inout  wire         npdsDtack,
  output logic [15:0] ctrlReg,
  output logic        regWrStb,
  output logic [2:0]  regWrIdx
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
  localparam logic [2:0] ID_INDEX  = 3'd7;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q;
  logic        rnw_q;
  logic        uds_q;      // latched lane enables, active high
  logic        lds_q;
  logic [15:0] dataOut_q;
  logic [15:0] regs_q [0:7];
  logic        wrStb_q;
  logic [2:0]  wrIdx_q;

  logic        hit_w;
  logic        wrEn_w;
  logic [15:0] rdMux_w;
  logic        dtackDrv_w;
  logic        dataOe_w;

  // Only the register index and the window-select byte are decoded; the
  // middle address bits are deliberately ignored so the file aliases.
  logic addr_unused_w;
  assign addr_unused_w = ^pdsAddr[15:4];

  assign hit_w = ~npdsAs & (~npdsUds | ~npdsLds) & (pdsAddr[23:16] == BASE_ADDR);

  // Write commits on the WAIT-to-ACK edge, so it shares that exact condition.
  assign wrEn_w = (state_q == ST_WAIT) & ~npdsAs & (cnt_q == 4'd0) & ~rnw_q;

  assign rdMux_w = (pdsAddr[3:1] == ID_INDEX) ? ID_VALUE : regs_q[pdsAddr[3:1]];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge pdsC8m or negedge npdsReset) begin
    if (!npdsReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_w) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        // Master dropping AS before DTACK is an abort; nothing is committed.
        if (npdsAs) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (npdsAs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. DTACK follows the state register directly, so an
  // asynchronous reset during ACK releases it without waiting for a clock.
  // --------------------------------------------------------------------------
  always_comb begin
    dtackDrv_w = 1'b0;
    dataOe_w   = 1'b0;
    case (state_q)
      ST_WAIT: dataOe_w = rnw_q;
      ST_ACK: begin
        dtackDrv_w = 1'b1;
        dataOe_w   = rnw_q;
      end
      default: begin
        dtackDrv_w = 1'b0;
        dataOe_w   = 1'b0;
      end
    endcase
  end

  assign npdsDtack  = dtackDrv_w ? 1'b0 : 1'bz;
  assign pdsDataOe  = dataOe_w;
  assign pdsDataOut = dataOut_q;
  assign ctrlReg    = regs_q[0];
  assign regWrStb   = wrStb_q;
  assign regWrIdx   = wrIdx_q;

  // --------------------------------------------------------------------------
  // Cycle attributes and read data are captured once at decode and held;
  // strobe changes later in the cycle are intentionally ignored.
  // --------------------------------------------------------------------------
  always_ff @(posedge pdsC8m or negedge npdsReset) begin
    if (!npdsReset) begin
      idx_q     <= 3'd0;
      rnw_q     <= 1'b0;
      uds_q     <= 1'b0;
      lds_q     <= 1'b0;
      dataOut_q <= 16'h0000;
    end else if ((state_q == ST_IDLE) && hit_w) begin
      idx_q     <= pdsAddr[3:1];
      rnw_q     <= pdsRnW;
      uds_q     <= ~npdsUds;
      lds_q     <= ~npdsLds;
      dataOut_q <= rdMux_w;
    end
  end

  // --------------------------------------------------------------------------
  // Register file and write notification
  // --------------------------------------------------------------------------
  always_ff @(posedge pdsC8m or negedge npdsReset) begin
    if (!npdsReset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
      wrStb_q <= 1'b0;
      wrIdx_q <= 3'd0;
    end else begin
      wrStb_q <= wrEn_w;
      if (wrEn_w) begin
        wrIdx_q <= idx_q;
        // The ID slot is acknowledged and reported but never modified.
        if (idx_q != ID_INDEX) begin
          if (uds_q) regs_q[idx_q][15:8] <= pdsDataIn[15:8];
          if (lds_q) regs_q[idx_q][7:0]  <= pdsDataIn[7:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pds_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_pds_target
// Purpose  : Directed self-checking bench for pds_target. Two instances share
//            the bus: one with WAIT_STATES=1, one with WAIT_STATES=3, each
//            with its own address strobe and DTACK line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pds_target;

  logic        clk;
  logic        rstN;
  logic        asN1, asN3;
  logic        udsN, ldsN;
  logic        rnw;
  logic [23:1] addr;
  logic [15:0] wdata;

  logic [15:0] dOut1, dOut3, ctrl1, ctrl3;
  logic        oe1, oe3, stb1, stb3;
  logic [2:0]  idx1, idx3;
  wire         dtack1, dtack3;

  pullup (dtack1);
  pullup (dtack3);

  int nCmp = 0;
  int nErr = 0;

  pds_target #(.BASE_ADDR(8'hF8), .WAIT_STATES(1), .ID_VALUE(16'h5E30)) u_dut1 (
    .pdsC8m(clk), .npdsReset(rstN), .npdsAs(asN1), .npdsUds(udsN), .npdsLds(ldsN),
    .pdsRnW(rnw), .pdsAddr(addr), .pdsDataIn(wdata), .pdsDataOut(dOut1),
    .pdsDataOe(oe1), .npdsDtack(dtack1), .ctrlReg(ctrl1), .regWrStb(stb1),
    .regWrIdx(idx1)
  );

  pds_target #(.BASE_ADDR(8'hF8), .WAIT_STATES(3), .ID_VALUE(16'h5E30)) u_dut3 (
    .pdsC8m(clk), .npdsReset(rstN), .npdsAs(asN3), .npdsUds(udsN), .npdsLds(ldsN),
    .pdsRnW(rnw), .pdsAddr(addr), .pdsDataIn(wdata), .pdsDataOut(dOut3),
    .pdsDataOe(oe3), .npdsDtack(dtack3), .ctrlReg(ctrl3), .regWrStb(stb3),
    .regWrIdx(idx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus cycle on the selected instance. dtackCyc counts rising edges
  // from the edge that samples the hit (edge 1); -1 means no DTACK seen.
  // abortAt > 0 releases AS right after that edge's sample.
  task automatic bus_cycle(input bit sel3, input logic [23:0] byteAddr, input bit rd,
                           input bit uN, input bit lN, input logic [15:0] wd,
                           input int abortAt, output int dtackCyc,
                           output logic [15:0] rdata, output logic oeSeen,
                           output int stbCnt, output logic [2:0] stbIdx,
                           output logic released);
    dtackCyc = -1; rdata = 16'h0; oeSeen = 1'b0; stbCnt = 0; stbIdx = 3'd0;
    released = 1'b0;
    @(negedge clk);
    addr = byteAddr[23:1]; rnw = rd; udsN = uN; ldsN = lN; wdata = wd;
    if (sel3) asN3 = 1'b0; else asN1 = 1'b0;
    for (int k = 1; k <= 20 && dtackCyc < 0; k++) begin
      @(posedge clk); #1;
      if ((sel3 ? dtack3 : dtack1) == 1'b0) dtackCyc = k;
      if (sel3 ? oe3 : oe1) oeSeen = 1'b1;
      if (sel3 ? stb3 : stb1) begin
        stbCnt++;
        stbIdx = sel3 ? idx3 : idx1;
      end
      rdata = sel3 ? dOut3 : dOut1;
      if (k == abortAt) begin
        @(negedge clk);
        asN1 = 1'b1; asN3 = 1'b1; udsN = 1'b1; ldsN = 1'b1;
      end
    end
    @(negedge clk);
    asN1 = 1'b1; asN3 = 1'b1; udsN = 1'b1; ldsN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) released = (sel3 ? dtack3 : dtack1);
      if (sel3 ? stb3 : stb1) begin
        stbCnt++;
        stbIdx = sel3 ? idx3 : idx1;
      end
    end
  endtask

  int          dc, sc;
  logic [15:0] rd;
  logic        oe, rel;
  logic [2:0]  si;
  bit          seen;

  initial begin
    rstN = 1'b0; asN1 = 1'b1; asN3 = 1'b1; udsN = 1'b1; ldsN = 1'b1;
    rnw = 1'b1; addr = '0; wdata = 16'h0;
    #1;
    check("rst_dtack_z", {31'b0, dtack1}, 32'd1);
    check("rst_oe",      {31'b0, oe1},    32'd0);
    check("rst_dout",    {16'b0, dOut1},  32'h0);
    check("rst_ctrl",    {16'b0, ctrl1},  32'h0);
    check("rst_stb",     {31'b0, stb1},   32'd0);
    check("rst_idx",     {29'b0, idx1},   32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Word write and readback, WAIT_STATES=1 -> DTACK at edge 3
    bus_cycle(0, 24'hF80004, 0, 0, 0, 16'hA5C3, 0, dc, rd, oe, sc, si, rel);
    check("wr_lat",     dc, 32'd3);
    check("wr_stb_cnt", sc, 32'd1);
    check("wr_stb_idx", {29'b0, si}, 32'd2);
    check("wr_oe",      {31'b0, oe}, 32'd0);
    check("wr_release", {31'b0, rel}, 32'd1);
    bus_cycle(0, 24'hF80004, 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
    check("rd_lat",  dc, 32'd3);
    check("rd_data", {16'b0, rd}, 32'hA5C3);
    check("rd_oe",   {31'b0, oe}, 32'd1);
    check("rd_stb",  sc, 32'd0);

    // Byte lanes on register 3
    bus_cycle(0, 24'hF80006, 0, 0, 0, 16'hFFFF, 0, dc, rd, oe, sc, si, rel);
    bus_cycle(0, 24'hF80006, 0, 0, 1, 16'h1234, 0, dc, rd, oe, sc, si, rel);
    bus_cycle(0, 24'hF80006, 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
    check("uds_only", {16'b0, rd}, 32'h12FF);
    bus_cycle(0, 24'hF80006, 0, 1, 0, 16'h0056, 0, dc, rd, oe, sc, si, rel);
    bus_cycle(0, 24'hF80006, 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
    check("lds_only", {16'b0, rd}, 32'h1256);

    // ID register: readable, write acknowledged but discarded
    bus_cycle(0, 24'hF8000E, 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
    check("id_read", {16'b0, rd}, 32'h5E30);
    bus_cycle(0, 24'hF8000E, 0, 0, 0, 16'h0000, 0, dc, rd, oe, sc, si, rel);
    check("id_wr_lat", dc, 32'd3);
    check("id_wr_stb", sc, 32'd1);
    check("id_wr_idx", {29'b0, si}, 32'd7);
    bus_cycle(0, 24'hF8000E, 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
    check("id_protect", {16'b0, rd}, 32'h5E30);

    // Miss: no DTACK, no OE, no write
    bus_cycle(0, 24'hF70002, 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
    check("miss_rd_dtack", dc, 32'hFFFF_FFFF);
    check("miss_rd_oe",    {31'b0, oe}, 32'd0);
    bus_cycle(0, 24'hF70002, 0, 0, 0, 16'hBEEF, 0, dc, rd, oe, sc, si, rel);
    check("miss_wr_dtack", dc, 32'hFFFF_FFFF);
    check("miss_wr_stb",   sc, 32'd0);
    bus_cycle(0, 24'hF80002, 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
    check("miss_no_change", {16'b0, rd}, 32'h0000);

    // Alias: F81230 -> index 0
    bus_cycle(0, 24'hF81230, 0, 0, 0, 16'h0001, 0, dc, rd, oe, sc, si, rel);
    check("alias_idx",  {29'b0, si}, 32'd0);
    check("alias_ctrl", {16'b0, ctrl1}, 32'h0001);

    // Abort on WAIT_STATES=3 instance: AS released two cycles after the hit
    bus_cycle(1, 24'hF80008, 0, 0, 0, 16'h7777, 2, dc, rd, oe, sc, si, rel);
    check("abort_dtack", dc, 32'hFFFF_FFFF);
    check("abort_stb",   sc, 32'd0);
    bus_cycle(1, 24'hF80008, 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
    check("abort_no_wr", {16'b0, rd}, 32'h0000);
    check("ws3_rd_lat",  dc, 32'd5);
    bus_cycle(1, 24'hF80008, 0, 0, 0, 16'h4321, 0, dc, rd, oe, sc, si, rel);
    check("ws3_wr_lat", dc, 32'd5);
    check("ws3_wr_stb", sc, 32'd1);
    bus_cycle(1, 24'hF80008, 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
    check("ws3_wr_data", {16'b0, rd}, 32'h4321);

    // Reset in the middle of a read ACK
    @(negedge clk);
    addr = 23'(24'hF80004 >> 1); rnw = 1'b1; udsN = 1'b0; ldsN = 1'b0; asN1 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (dtack1 == 1'b0) seen = 1'b1;
    end
    check("rstack_seen", {31'b0, seen}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("rstack_dtack", {31'b0, dtack1}, 32'd1);
    check("rstack_oe",    {31'b0, oe1},    32'd0);
    check("rstack_ctrl",  {16'b0, ctrl1},  32'h0);
    @(negedge clk);
    asN1 = 1'b1; udsN = 1'b1; ldsN = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus_cycle(0, 24'hF80000 + 24'(2 * i), 1, 0, 0, 16'h0, 0, dc, rd, oe, sc, si, rel);
      check($sformatf("post_rst_reg%0d", i), {16'b0, rd}, 32'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
`default_nettype wire
